// File: rtl/segment_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
// Latency: n/a (constants, types and helper functions only).
// Backpressure: n/a.
//
// Contents: active-high segment codes (bit0=a .. bit6=g), the scan FSM
// state type and an elaboration-time legality check for the field width.
package segment_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  // A field must hold at least 0..9 and never more than 0..127; the tens
  // digit of anything up to 127 still fits in 4 bits.
  function automatic bit field_w_ok(input int w);
    return (w >= 4) && (w <= 7);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-high 7-segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   digit_i  4-bit decimal digit (values above 9 decode to blank)
//   blank_i  force all segments off (highest priority)
//   dash_i   show a dash instead of the digit
//   seg_o    active-high segments, bit0=a .. bit6=g
module seg7_decode
  import segment_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (dash_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/segment_scanner.sv
// Multiplexed 7-segment driver: scans 2*FIELDS digits with on/blank phases.
// Latency: enable seen at an edge gives digit 0 ON from that edge; outputs
// Backpressure: none, free-running once enabled; outputs are registered-state decode.
//
// Ports:
//   clock, reset (async, active-low)
//   enable       scan enable, low forces IDLE on the next edge
//   data_show    FIELDS binary fields, field f at [f*FIELD_W +: FIELD_W]
//   lz_blank     per-field suppression of a zero tens digit
//   blink_mask   per-field blanking during the blink-off phase
//   digit_en     one-hot digit select (inverted when COMMON_ANODE)
//   segment      bit0=a .. bit6=g (inverted when COMMON_ANODE)
//   colon        high in ON cycles of the blink-on phase
//   frame_start  high on the first ON cycle of digit 0
module segment_scanner
  import segment_pkg::*;
#(
  parameter int FIELDS       = 2,
  parameter int FIELD_W      = 6,
  parameter int ON_CYCLES    = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 256,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [FIELDS*FIELD_W-1:0] data_show,
  input  logic [FIELDS-1:0]         lz_blank,
  input  logic [FIELDS-1:0]         blink_mask,
  output logic [2*FIELDS-1:0]       digit_en,
  output logic [6:0]                segment,
  output logic                      colon,
  output logic                      frame_start
);

  localparam int NDIG    = 2 * FIELDS;
  localparam int DIG_W   = $clog2(NDIG);
  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [FR_W-1:0]  FR_LAST    = FR_W'(BLINK_FRAMES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NDIG - 1);
  localparam logic [NDIG-1:0]  DIG0_HOT   = {{(NDIG-1){1'b0}}, 1'b1};

  if (!field_w_ok(FIELD_W)) begin : g_bad_field_w
    $error("segment_scanner: FIELD_W must be in 4..7");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  scan_state_e               state_q, state_d;
  logic [DIG_W-1:0]          digit_q, digit_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [FR_W-1:0]           frame_q, frame_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [FIELDS*FIELD_W-1:0] snap_data_q, snap_data_d;
  logic [FIELDS-1:0]         snap_lz_q, snap_lz_d;
  logic [FIELDS-1:0]         snap_blink_q, snap_blink_d;

  logic slot_done;
  logic snap_load;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      digit_q       <= '0;
      cnt_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      snap_data_q   <= '0;
      snap_lz_q     <= '0;
      snap_blink_q  <= '0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      snap_data_q   <= snap_data_d;
      snap_lz_q     <= snap_lz_d;
      snap_blink_q  <= snap_blink_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: enable low overrides everything, so a wrap coinciding with
  // disable neither snapshots, pulses frame_start nor advances the blink count.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    snap_data_d   = snap_data_q;
    snap_lz_d     = snap_lz_q;
    snap_blink_d  = snap_blink_q;
    slot_done     = 1'b0;
    snap_load     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ON;
          digit_d   = '0;
          cnt_d     = '0;
          snap_load = 1'b1;
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES > 0) begin
              state_d = BLANK;
            end else begin
              slot_done = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d     = '0;
            slot_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (slot_done) begin
        state_d = ON;
        if (digit_q == DIG_LAST) begin
          digit_d   = '0;
          snap_load = 1'b1;
          if (frame_q == FR_LAST) begin
            frame_d       = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end
    end

    if (snap_load) begin
      snap_data_d  = data_show;
      snap_lz_d    = lz_blank;
      snap_blink_d = blink_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-field binary to two decimal digits, from the snapshot only.
  // ---------------------------------------------------------------------------
  logic [3:0] tens [FIELDS];
  logic [3:0] ones [FIELDS];
  logic       over [FIELDS];

  for (genvar f = 0; f < FIELDS; f++) begin : g_field
    logic [6:0] v7;
    assign v7      = 7'(snap_data_q[f*FIELD_W +: FIELD_W]);
    assign tens[f] = 4'(v7 / 7'd10);
    assign ones[f] = 4'(v7 % 7'd10);
    assign over[f] = (v7 > 7'd99);
  end

  // Pick the field/digit under scan. Blink blanking beats everything; a dash
  // beats leading-zero suppression, so lz only applies when not over range.
  logic [3:0] sel_digit;
  logic       sel_blank;
  logic       sel_dash;

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    sel_dash  = 1'b0;
    for (int f = 0; f < FIELDS; f++) begin
      if ((digit_q >> 1) == DIG_W'(f)) begin
        sel_dash  = over[f];
        sel_digit = digit_q[0] ? tens[f] : ones[f];
        sel_blank = (blink_phase_q && snap_blink_q[f]) ||
                    (digit_q[0] && snap_lz_q[f] && (tens[f] == 4'd0) && !over[f]);
      end
    end
  end

  logic [6:0] seg_dec;

  seg7_decode u_decode (
    .digit_i (sel_digit),
    .blank_i (sel_blank),
    .dash_i  (sel_dash),
    .seg_o   (seg_dec)
  );

  // ---------------------------------------------------------------------------
  // Outputs: a blanked digit keeps digit_en asserted so duty cycle is uniform.
  // ---------------------------------------------------------------------------
  logic            scan_on;
  logic [NDIG-1:0] den_act;
  logic [6:0]      seg_act;

  assign scan_on = (state_q == ON);
  assign den_act = scan_on ? (DIG0_HOT << digit_q) : '0;
  assign seg_act = scan_on ? seg_dec : SEG_BLANK;

  assign digit_en    = COMMON_ANODE ? ~den_act : den_act;
  assign segment     = COMMON_ANODE ? ~seg_act : seg_act;
  assign colon       = scan_on && !blink_phase_q;
  assign frame_start = scan_on && (digit_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_segment_scanner.sv
// Scoreboard bench for segment_scanner: a frame-arithmetic reference model
// predicts every cycle's outputs, a negedge monitor compares both polarities.
module tb_segment_scanner;

  localparam int FIELDS  = 2;
  localparam int FIELD_W = 7;
  localparam int ON_C    = 4;
  localparam int BLANK_C = 1;
  localparam int BF      = 2;
  localparam int NDIG    = 2 * FIELDS;
  localparam int SLOT    = ON_C + BLANK_C;
  localparam int PERIOD  = NDIG * SLOT;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic                      enable = 1'b0;
  logic [FIELDS*FIELD_W-1:0] data_show = '0;
  logic [FIELDS-1:0]         lz_blank = '0;
  logic [FIELDS-1:0]         blink_mask = '0;

  logic [NDIG-1:0] den, den_ca;
  logic [6:0]      seg, seg_ca;
  logic            colon, colon_ca, fs, fs_ca;

  segment_scanner #(
    .FIELDS(FIELDS), .FIELD_W(FIELD_W), .ON_CYCLES(ON_C), .BLANK_CYCLES(BLANK_C),
    .BLINK_FRAMES(BF), .COMMON_ANODE(1'b0)
  ) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .data_show(data_show),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .digit_en(den),
    .segment(seg), .colon(colon), .frame_start(fs)
  );

  segment_scanner #(
    .FIELDS(FIELDS), .FIELD_W(FIELD_W), .ON_CYCLES(ON_C), .BLANK_CYCLES(BLANK_C),
    .BLINK_FRAMES(BF), .COMMON_ANODE(1'b1)
  ) u_dut_ca (
    .clock(clock), .reset(reset), .enable(enable), .data_show(data_show),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .digit_en(den_ca),
    .segment(seg_ca), .colon(colon_ca), .frame_start(fs_ca)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NDIG-1:0] den;
    logic [6:0]      seg;
    logic            colon;
    logic            fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: position inside the scan, frames completed, snapshot.
  bit                        m_run = 1'b0;
  int                        m_t = 0;
  int                        m_wraps = 0;
  logic [FIELDS*FIELD_W-1:0] m_data = '0;
  logic [FIELDS-1:0]         m_lz = '0;
  logic [FIELDS-1:0]         m_mask = '0;

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   d, f, v;
    bit   blink_off;
    e = '0;
    if (m_run && ((m_t % SLOT) < ON_C)) begin
      d         = m_t / SLOT;
      f         = d / 2;
      v         = int'((m_data >> (f * FIELD_W)) & 14'h7F);
      blink_off = ((m_wraps / BF) % 2) == 1;
      e.den     = NDIG'(1 << d);
      e.colon   = !blink_off;
      e.fs      = (m_t == 0);
      if (blink_off && m_mask[f])        e.seg = 7'h00;
      else if (v > 99)                   e.seg = 7'h40;
      else if (d % 2 == 1)               e.seg = (m_lz[f] && (v / 10 == 0)) ? 7'h00 : seg_code(v / 10);
      else                               e.seg = seg_code(v % 10);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs the DUT sees at this edge.
  task automatic step();
    @(posedge clock);
    if (!reset) begin
      m_run = 1'b0; m_t = 0; m_wraps = 0; m_data = '0; m_lz = '0; m_mask = '0;
    end else if (!enable) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0;
      m_data = data_show; m_lz = lz_blank; m_mask = blink_mask;
    end else begin
      m_t++;
      if (m_t == PERIOD) begin
        m_t = 0;
        m_wraps++;
        m_data = data_show; m_lz = lz_blank; m_mask = blink_mask;
      end
    end
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic run_until_t(input int t);
    for (int i = 0; i < 4 * PERIOD && !(m_run && m_t == t); i++) step();
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t       e;
    logic [NDIG-1:0] inv_den;
    logic [6:0] inv_seg;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        inv_den = ~e.den;
        inv_seg = ~e.seg;
        check("digit_en",       32'(den),      32'(e.den));
        check("segment",        32'(seg),      32'(e.seg));
        check("colon",          32'(colon),    32'(e.colon));
        check("frame_start",    32'(fs),       32'(e.fs));
        check("ca_digit_en",    32'(den_ca),   32'(inv_den));
        check("ca_segment",     32'(seg_ca),   32'(inv_seg));
        check("ca_colon",       32'(colon_ca), 32'(e.colon));
        check("ca_frame_start", 32'(fs_ca),    32'(e.fs));
      end
    end
  end

  task automatic check_inactive(input string tag);
    check({tag, "_digit_en"},    32'(den),      32'h0);
    check({tag, "_segment"},     32'(seg),      32'h0);
    check({tag, "_colon"},       32'(colon),    32'h0);
    check({tag, "_frame_start"}, 32'(fs),       32'h0);
    check({tag, "_ca_digit_en"}, 32'(den_ca),   32'hF);
    check({tag, "_ca_segment"},  32'(seg_ca),   32'h7F);
  endtask

  initial begin
    #1;
    check_inactive("reset");
    repeat (3) step();
    reset = 1'b1;
    step();

    // Basic scan of 12 / 34.
    data_show = {7'd12, 7'd34};
    enable    = 1'b1;
    repeat (2 * PERIOD) step();

    // Snapshot coherence: change field 0 while digit 2 is on.
    run_until_t(2 * SLOT + 1);
    data_show = {7'd12, 7'd56};
    repeat (2 * PERIOD) step();

    // Leading-zero blanking and over-range dash.
    data_show = {7'd100, 7'd7};
    lz_blank  = 2'b01;
    repeat (2 * PERIOD) step();
    lz_blank  = 2'b11;
    data_show = {7'd5, 7'd99};
    repeat (PERIOD) step();

    // Blink on field 1 over several half-periods.
    data_show  = {7'd12, 7'd34};
    lz_blank   = 2'b00;
    blink_mask = 2'b10;
    repeat (8 * PERIOD) step();

    // Enable drop mid-frame, then restart.
    run_until_t(7);
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (PERIOD + 3) step();

    // Asynchronous reset mid-frame: outputs go inactive without a clock edge.
    run_until_t(11);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_inactive("async_reset");
    repeat (2) step();
    reset = 1'b1;
    repeat (2 * PERIOD) step();

    // Randomized inputs with occasional enable drops.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        data_show = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
        lz_blank  = 2'($urandom_range(0, 3));
        blink_mask = 2'($urandom_range(0, 3));
      end
      enable = ($urandom_range(0, 99) != 0);
      step();
    end

    enable = 1'b0;
    repeat (2) step();
    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
